// File: rtl/day01_rot_scheduler.sv
// Front-end for the day-01 dial stepper: parses "L68\n"-style ASCII into rotation commands,
// buffers them in a small FIFO and hands them to the engine one at a time.
module day01_rot_scheduler #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STEP_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              cmd_valid,
  output logic              cmd_dir,
  output logic [STEP_W-1:0] cmd_steps,
  input  logic              eng_ready,
  output logic [31:0]       cmd_issued,
  output logic              parse_err,
  output logic              done
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned EntW = STEP_W + 1;
  localparam logic [PtrW:0] PtrOne = {{PtrW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {PIdle, PNum, PEnd} pstate_e;

  pstate_e             state_q, state_d;
  logic                dir_q, dir_d;
  logic [STEP_W-1:0]   acc_q, acc_d;
  logic                has_digit_q, has_digit_d;
  logic                err_q, err_d;

  logic [EntW-1:0]     mem_q [FIFO_DEPTH];
  logic [PtrW:0]       wr_ptr_q, rd_ptr_q;
  logic [31:0]         issued_q;
  logic                hs_q;
  logic                done_q;

  logic                fifo_empty, fifo_full;
  logic                accept, push, pop;
  logic                is_digit;
  logic [3:0]          digit;
  logic [STEP_W+3:0]   acc_next;
  logic [EntW-1:0]     head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

  // Gated by rst so the interface reads not-ready during the reset cycle itself.
  assign in_ready = !rst && (state_q != PEnd) && !fifo_full;
  assign accept   = in_valid && in_ready;

  assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign digit    = in_data[3:0];
  // acc*10 + d computed with 4 guard bits so overflow shows up in the top nibble.
  assign acc_next = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1) + {{STEP_W{1'b0}}, digit};

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    acc_d       = acc_q;
    has_digit_d = has_digit_q;
    err_d       = err_q;
    push        = 1'b0;
    if (accept) begin
      unique case (state_q)
        PIdle: begin
          if (in_data == 8'h4C || in_data == 8'h52) begin
            dir_d       = (in_data == 8'h52);
            acc_d       = '0;
            has_digit_d = 1'b0;
            state_d     = PNum;
          end else if (in_data != 8'h0A && in_data != 8'h0D) begin
            err_d = 1'b1;
          end
        end
        PNum: begin
          if (is_digit) begin
            has_digit_d = 1'b1;
            if (|acc_next[STEP_W+3:STEP_W]) begin
              acc_d = '1;
              err_d = 1'b1;
            end else begin
              acc_d = acc_next[STEP_W-1:0];
            end
          end else if (in_data == 8'h0A) begin
            push    = 1'b1;
            state_d = PIdle;
          end else if (in_data != 8'h0D) begin
            err_d   = 1'b1;
            state_d = PIdle;
          end
        end
        default: ;
      endcase
      // Final byte: flush a newline-less command that already has digits.
      if (in_last) begin
        if (state_d == PNum && has_digit_d) push = 1'b1;
        state_d = PEnd;
      end
    end
  end

  assign head      = mem_q[rd_ptr_q[PtrW-1:0]];
  assign cmd_valid = !fifo_empty;
  assign cmd_dir   = cmd_valid & head[STEP_W];
  assign cmd_steps = cmd_valid ? head[STEP_W-1:0] : '0;
  assign pop       = cmd_valid && eng_ready;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PtrW-1:0]] <= {dir_d, acc_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PIdle;
      dir_q       <= 1'b0;
      acc_q       <= '0;
      has_digit_q <= 1'b0;
      err_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      issued_q    <= '0;
      hs_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      acc_q       <= acc_d;
      has_digit_q <= has_digit_d;
      err_q       <= err_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
        issued_q <= issued_q + 32'd1;
      end
      hs_q <= pop;
      // hs_q masks the cycle where the engine's registered ready has not yet dropped.
      if (state_q == PEnd && fifo_empty && eng_ready && !hs_q) done_q <= 1'b1;
    end
  end

  assign cmd_issued = issued_q;
  assign parse_err  = err_q;
  assign done       = done_q;

endmodule

// File: tb/tb_day01_rot_scheduler.sv
// Bench for day01_rot_scheduler: directed streams plus random streams checked against a
// byte-level reference parser and a behavioural stepper engine with a mod-100 dial.
module tb_day01_rot_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        cmd_valid;
  logic        cmd_dir;
  logic [31:0] cmd_steps;
  logic        eng_ready = 1'b1;
  logic [31:0] cmd_issued;
  logic        parse_err;
  logic        done;

  day01_rot_scheduler #(.FIFO_DEPTH(4), .STEP_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .cmd_valid (cmd_valid),
    .cmd_dir   (cmd_dir),
    .cmd_steps (cmd_steps),
    .eng_ready (eng_ready),
    .cmd_issued(cmd_issued),
    .parse_err (parse_err),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  logic [7:0]  stim[$];
  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];
  bit          exp_err;

  bit hold = 1'b0;
  bit acc_pend = 1'b0;
  bit running = 1'b0;
  bit early = 1'b0;
  int busy = 0;
  int dial = 50;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Engine: ready drops for the cycle after each accept, then stays low for a random while.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        eng_ready = 1'b1;
        acc_pend  = 1'b0;
        busy      = 0;
        dial      = 50;
        got_q.delete();
      end else begin
        if (acc_pend) begin
          eng_ready = 1'b0;
          busy      = $urandom_range(0, 3);
          acc_pend  = 1'b0;
        end else if (!eng_ready) begin
          if (busy > 0) busy--;
          else eng_ready = 1'b1;
        end
        if (hold) eng_ready = 1'b0;
        if (eng_ready && cmd_valid) begin
          got_q.push_back({cmd_dir, cmd_steps});
          if (cmd_dir) dial = (dial + int'(cmd_steps % 100)) % 100;
          else dial = (dial + 100 - int'(cmd_steps % 100)) % 100;
          acc_pend = 1'b1;
        end
        if (running && done && got_q.size() < exp_q.size()) early = 1'b1;
      end
    end
  end

  // Reference parser over the whole byte stream, using wide arithmetic for saturation.
  function automatic void model(input bit use_last);
    int               mode = 0;
    longint unsigned  acc = 0;
    bit               dir = 1'b0;
    bit               any = 1'b0;
    logic [7:0]       c;
    longint unsigned  maxv = 64'hFFFF_FFFF;
    exp_q.delete();
    exp_err = 1'b0;
    for (int i = 0; i < stim.size(); i++) begin
      c = stim[i];
      if (mode == 0) begin
        if (c == "L" || c == "R") begin
          dir = (c == "R");
          acc = 0;
          any = 1'b0;
          mode = 1;
        end else if (c != 8'h0A && c != 8'h0D) begin
          exp_err = 1'b1;
        end
      end else if (c >= "0" && c <= "9") begin
        acc = acc * 10 + (longint'(c) - 48);
        any = 1'b1;
        if (acc > maxv) begin
          acc = maxv;
          exp_err = 1'b1;
        end
      end else if (c == 8'h0A) begin
        exp_q.push_back({dir, acc[31:0]});
        mode = 0;
      end else if (c != 8'h0D) begin
        exp_err = 1'b1;
        mode = 0;
      end
    end
    if (use_last && mode == 1 && any) exp_q.push_back({dir, acc[31:0]});
  endfunction

  task automatic load(input string s);
    stim.delete();
    for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
  endtask

  task automatic gen_random();
    int n;
    int nd;
    int r;
    n = $urandom_range(1, 8);
    stim.delete();
    for (int k = 0; k < n; k++) begin
      r = $urandom_range(0, 15);
      if (r == 0) stim.push_back("X");
      stim.push_back($urandom_range(0, 1) ? "R" : "L");
      nd = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 12) : $urandom_range(1, 3);
      for (int d = 0; d < nd; d++) stim.push_back(8'h30 + 8'($urandom_range(0, 9)));
      if (r == 1) stim.push_back("?");
      if (r == 2) stim.push_back(8'h0D);
      if (!(k == n - 1 && r >= 12)) stim.push_back(8'h0A);
    end
  endtask

  task automatic send_stream(input bit use_last);
    int tmo;
    for (int i = 0; i < stim.size(); i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      in_valid = 1'b1;
      in_data  = stim[i];
      in_last  = use_last && (i == stim.size() - 1);
      tmo = 0;
      while (!in_ready && tmo < 500) begin
        @(negedge clk);
        tmo++;
      end
      if (tmo >= 500) begin
        chk("in_ready_timeout", 1, 0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    hold     = 1'b0;
    running  = 1'b0;
    @(negedge clk);
    chk({tag, "_in_ready_rst"}, in_ready, 0);
    chk({tag, "_cmd_valid"}, cmd_valid, 0);
    chk({tag, "_cmd_dir"}, cmd_dir, 0);
    chk({tag, "_cmd_steps"}, cmd_steps, 0);
    chk({tag, "_cmd_issued"}, cmd_issued, 0);
    chk({tag, "_parse_err"}, parse_err, 0);
    chk({tag, "_done"}, done, 0);
    rst = 1'b0;
    #1;
    chk({tag, "_in_ready_post"}, in_ready, 1);
    got_q.delete();
    early = 1'b0;
  endtask

  task automatic finish_run(input string tag);
    int tmo = 0;
    while ((got_q.size() < exp_q.size() || !done) && tmo < 3000) begin
      @(negedge clk);
      tmo++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) chk({tag, "_cmd"}, got_q[i], exp_q[i]);
    chk({tag, "_issued"}, cmd_issued, exp_q.size());
    chk({tag, "_parse_err"}, parse_err, exp_err);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_done_early"}, early, 0);
    chk({tag, "_in_ready_end"}, in_ready, 0);
    running = 1'b0;
  endtask

  task automatic run(input string tag);
    model(1'b1);
    running = 1'b1;
    send_stream(1'b1);
    finish_run(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    do_reset("init");

    load("L68\nR30\n");
    run("t1");
    chk("t1_dial", dial, 12);

    do_reset("t2r");
    load("R5");
    run("t2");

    do_reset("t3r");
    load("R1\nR2\nR3\nR4\nR5\nR6\n");
    model(1'b1);
    hold = 1'b1;
    running = 1'b1;
    fork
      send_stream(1'b1);
      begin
        repeat (60) @(negedge clk);
        chk("t3_in_ready_full", in_ready, 0);
        chk("t3_cmd_valid", cmd_valid, 1);
        chk("t3_issued_held", cmd_issued, 0);
        hold = 1'b0;
      end
    join
    finish_run("t3");

    do_reset("t4r");
    load("X1\nL7\n");
    run("t4");

    do_reset("t5r");
    load("R99999999999\n");
    run("t5");

    do_reset("t6r");
    load("L1\nR2\n");
    send_stream(1'b0);
    repeat (20) @(negedge clk);
    chk("t6_pre_issued", cmd_issued, 2);
    hold = 1'b1;
    load("R3\nR4\nL5\n");
    send_stream(1'b0);
    repeat (3) @(negedge clk);
    chk("t6_queued", cmd_valid, 1);
    do_reset("t6");
    load("R7\n");
    run("t6b");

    do_reset("e0r");
    load("\n");
    run("empty");

    for (int k = 0; k < 12; k++) begin
      do_reset("rndr");
      gen_random();
      run("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
